// File: rtl/ring_delay_pkg.sv
// ring_delay_pkg
//   Shared definitions for the ring_delay slice:
//     - rd_state_e : FILL/RUN state encodings (RD_FILL = 0, RD_RUN = 1)
//     - clog2()    : constant function used to derive pointer widths
package ring_delay_pkg;

    typedef enum logic {
        RD_FILL = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_e;

    // Ceiling log2 for elaboration-time width derivation (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/ring_delay_ram.sv
// ring_delay_ram
//   WIDTH x DEPTH storage with one synchronous write port and one
//   asynchronous read port (maps to distributed RAM).
//   Ports:
//     clk    in   write clock, rising edge
//     we     in   write enable
//     waddr  in   write slot
//     wdata  in   write data
//     raddr  in   read slot
//     rdata  out  read data, combinational from raddr and contents
module ring_delay_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it can map onto LUT RAM; a reset
    // port would force it into discrete flops. Contents are qualified by
    // out_valid in the parent instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ring_delay.sv
// ring_delay
//   Runtime-programmable delay line built on a circular buffer. out follows
//   in by delay_q clock-enabled cycles; out_valid marks that the buffer holds
//   delay_q genuine samples written since the last restart (reset or a
//   change of the clamped delay request).
//   Parameters:
//     MAX_DELAY  buffer depth and largest delay (>= 2)
//     WIDTH      sample width
//     AW         pointer width, derived
//   Ports:
//     clk        in   sole clock, rising edge
//     rst        in   asynchronous reset, active low
//     ce         in   clock enable; the stream advances only when ce = 1
//     delay      in   requested delay 0..MAX_DELAY, larger values clamp
//     in         in   input sample
//     out        out  delayed sample (combinational from registered state)
//     out_valid  out  registered, high exactly in the RUN state
//   Build option:
//     RING_DELAY_ZERO_FILL_EN  when defined, out is forced to 0 while
//                              out_valid is low.
module ring_delay
    import ring_delay_pkg::*;
#(
    parameter  int MAX_DELAY = 16,
    parameter  int WIDTH     = 8,
    localparam int AW        = clog2(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [AW:0]      delay,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam logic [AW:0]   MAX_D    = (AW + 1)'(MAX_DELAY);
    localparam logic [AW-1:0] LAST_PTR = AW'(MAX_DELAY - 1);

    rd_state_e        state_q, state_d;
    logic [AW:0]      fill_q, fill_d, fill_inc;
    logic [AW:0]      delay_q, delay_c;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      wr_ext, rd_sum;
    logic             restart;
    logic [WIDTH-1:0] rd_data, data_sel;

    assign delay_c = (delay > MAX_D) ? MAX_D : delay;
    assign restart = (delay_c != delay_q);

    // Read slot = (wr_ptr - delay_q) mod MAX_DELAY. Written as a compare
    // and add so it also holds when MAX_DELAY is not a power of two.
    assign wr_ext = {1'b0, wr_ptr};
    assign rd_sum = (wr_ext >= delay_q) ? (wr_ext - delay_q)
                                        : (wr_ext + (MAX_D - delay_q));
    assign rd_ptr = rd_sum[AW-1:0];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            delay_q <= '0;
            fill_q  <= '0;
            state_q <= RD_FILL;
        end else begin
            delay_q <= delay_c;
            fill_q  <= fill_d;
            state_q <= state_d;
            if (ce) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
        end
    end

    assign fill_inc = (fill_q == MAX_D) ? fill_q : fill_q + (AW + 1)'(ce);

    // NOTE: every output of this block is defaulted first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (restart) begin
            // A write on the restart edge counts as fill sample 1.
            state_d = RD_FILL;
            fill_d  = ce ? (AW + 1)'(1) : '0;
        end else begin
            case (state_q)
                RD_FILL: begin
                    fill_d = fill_inc;
                    if (fill_inc >= delay_q) begin
                        state_d = RD_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state_q == RD_RUN);

    ring_delay_ram #(
        .WIDTH (WIDTH),
        .DEPTH (MAX_DELAY),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ce),
        .waddr (wr_ptr),
        .wdata (in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // delay_q = 0 is passthrough; with delay_q = MAX_DELAY the read slot is
    // the one about to be overwritten, which still holds the oldest sample.
    assign data_sel = (delay_q == '0) ? in : rd_data;

`ifdef RING_DELAY_ZERO_FILL_EN
    assign out = out_valid ? data_sel : '0;
`else
    assign out = data_sel;
`endif

endmodule

// File: tb/tb_ring_delay.sv
// tb_ring_delay
//   Directed, self-checking bench for ring_delay (MAX_DELAY = 16, WIDTH = 8).
//   Each scenario task drives its stimulus and compares outputs against
//   hand-derived expectations; a single summary line closes the run.
module tb_ring_delay;

    logic       clk;
    logic       rst;
    logic       ce;
    logic [4:0] delay;
    logic [7:0] in;
    logic [7:0] out;
    logic       out_valid;

    int checks;
    int failures;

    ring_delay #(
        .MAX_DELAY (16),
        .WIDTH     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .delay     (delay),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, settle 1 time unit past it.
    task automatic step(input logic c, input logic [7:0] v);
        ce = c;
        in = v;
        @(posedge clk);
        #1;
    endtask

    // Reset with the given delay request on the pins; released 1 unit
    // after an edge so the next edge is the first one out of reset.
    task automatic do_reset(input logic [4:0] d);
        rst   = 1'b0;
        ce    = 1'b0;
        in    = 8'h00;
        delay = d;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst   = 1'b0;
        ce    = 1'b1;
        in    = 8'h77;
        delay = 5'd3;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
`ifdef RING_DELAY_ZERO_FILL_EN
        checks++;
        if (out !== 8'h00) begin
            failures++;
            $display("FAIL reset_out: got %h expected 00", out);
        end
`endif
    endtask

    // delay=3, ce always on, in = k on edge k: valid from edge 3, out = k-2.
    task automatic test_delay3;
        do_reset(5'd3);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 8'(k));
            checks++;
            if (out_valid !== (k >= 3)) begin
                failures++;
                $display("FAIL d3_valid k=%0d: got %b expected %b", k, out_valid, (k >= 3));
            end
            if (k >= 3) begin
                checks++;
                if (out !== 8'(k - 2)) begin
                    failures++;
                    $display("FAIL d3_out k=%0d: got %0d expected %0d", k, out, k - 2);
                end
            end
        end
    endtask

    // Same stream with ce alternating: results counted in ce edges, and
    // held across ce=0 edges even while in carries junk.
    task automatic test_ce_gap;
        do_reset(5'd3);
        for (int m = 1; m <= 8; m++) begin
            for (int ph = 0; ph < 2; ph++) begin
                if (ph == 0) step(1'b1, 8'(m));
                else         step(1'b0, 8'hEE);
                checks++;
                if (out_valid !== (m >= 3)) begin
                    failures++;
                    $display("FAIL gap_valid m=%0d ph=%0d: got %b expected %b", m, ph, out_valid, (m >= 3));
                end
                if (m >= 3) begin
                    checks++;
                    if (out !== 8'(m - 2)) begin
                        failures++;
                        $display("FAIL gap_out m=%0d ph=%0d: got %0d expected %0d", m, ph, out, m - 2);
                    end
                end
            end
        end
    endtask

    // delay=16 across pointer wrap: valid from edge 16, out = k-15.
    task automatic test_max;
        do_reset(5'd16);
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, 8'(k));
            checks++;
            if (out_valid !== (k >= 16)) begin
                failures++;
                $display("FAIL max_valid k=%0d: got %b expected %b", k, out_valid, (k >= 16));
            end
            if (k >= 16) begin
                checks++;
                if (out !== 8'(k - 15)) begin
                    failures++;
                    $display("FAIL max_out k=%0d: got %0d expected %0d", k, out, k - 15);
                end
            end
        end
    endtask

    // delay=0 passthrough, then delay=20 which clamps to 16.
    task automatic test_passthrough_clamp;
        do_reset(5'd0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL pt_pre_valid: got %b expected 0", out_valid);
        end
        step(1'b1, 8'd200);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL pt_valid: got %b expected 1", out_valid);
        end
        in = 8'h5A;
        #1;
        checks++;
        if (out !== 8'h5A) begin
            failures++;
            $display("FAIL pt_comb_5a: got %h expected 5a", out);
        end
        in = 8'hC3;
        #1;
        checks++;
        if (out !== 8'hC3) begin
            failures++;
            $display("FAIL pt_comb_c3: got %h expected c3", out);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 8'(210 + k));
            checks++;
            if (out !== 8'(210 + k)) begin
                failures++;
                $display("FAIL pt_out k=%0d: got %0d expected %0d", k, out, 210 + k);
            end
        end
        delay = 5'd20;
        for (int j = 1; j <= 20; j++) begin
            step(1'b1, 8'(j));
            checks++;
            if (out_valid !== (j >= 16)) begin
                failures++;
                $display("FAIL clamp_valid j=%0d: got %b expected %b", j, out_valid, (j >= 16));
            end
            if (j >= 16) begin
                checks++;
                if (out !== 8'(j - 15)) begin
                    failures++;
                    $display("FAIL clamp_out j=%0d: got %0d expected %0d", j, out, j - 15);
                end
            end
        end
    endtask

    // Running at delay=4, shrink to 2 on a ce edge.
    task automatic test_shrink;
        do_reset(5'd4);
        for (int k = 1; k <= 8; k++) step(1'b1, 8'(k));
        checks++;
        if (out_valid !== 1'b1 || out !== 8'd5) begin
            failures++;
            $display("FAIL shrink_pre: got valid=%b out=%0d expected valid=1 out=5", out_valid, out);
        end
        delay = 5'd2;
        step(1'b1, 8'd9);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL shrink_drop: got %b expected 0", out_valid);
        end
        for (int k = 10; k <= 12; k++) begin
            step(1'b1, 8'(k));
            checks++;
            if (out_valid !== 1'b1 || out !== 8'(k - 1)) begin
                failures++;
                $display("FAIL shrink_run k=%0d: got valid=%b out=%0d expected valid=1 out=%0d", k, out_valid, out, k - 1);
            end
        end
    endtask

    // Asynchronous reset between edges, then refill as from power-up.
    task automatic test_async_reset;
        do_reset(5'd3);
        for (int k = 1; k <= 6; k++) step(1'b1, 8'(k));
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ar_pre_valid: got %b expected 1", out_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ar_valid: got %b expected 0", out_valid);
        end
`ifdef RING_DELAY_ZERO_FILL_EN
        checks++;
        if (out !== 8'h00) begin
            failures++;
            $display("FAIL ar_out: got %h expected 00", out);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 8'(50 + k));
            checks++;
            if (out_valid !== (k >= 3)) begin
                failures++;
                $display("FAIL ar_refill_valid k=%0d: got %b expected %b", k, out_valid, (k >= 3));
            end
            if (k >= 3) begin
                checks++;
                if (out !== 8'(48 + k)) begin
                    failures++;
                    $display("FAIL ar_refill_out k=%0d: got %0d expected %0d", k, out, 48 + k);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        ce       = 1'b0;
        in       = 8'h00;
        delay    = 5'd0;
        test_reset();
        test_delay3();
        test_ce_gap();
        test_max();
        test_passthrough_clamp();
        test_shrink();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
